// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing one synchronous FIFO write port among NREQ
//   producers. The grant is combinational: the granted word is written into
//   the FIFO on the same clock edge at which gnt is high. A burst quota lets
//   the current owner take up to BURST consecutive words before the
//   round-robin pointer moves on, so short packets stay contiguous.
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         synchronous active-high reset
//   req         per-requester valid
//   req_data    packed words, requester i on [i*WIDTH +: WIDTH]
//   req_en      per-requester enable mask (req[i] ignored when 0)
//   gnt         one-hot or zero grant, word accepted this cycle
//   fifo_full   FIFO cannot accept a write this cycle
//   fifo_write  FIFO write strobe
//   fifo_data   FIFO write data (0 when idle)
//   owner       index of last granted requester (registered)
//   burst_cnt   consecutive grants issued to owner (registered)
// -----------------------------------------------------------------------------

// Per-requester slice: effective request and grant-gated data for the
// AND-OR output mux.
module fifo_wr_arbiter_lane #(
   parameter int WIDTH = 8
) (
   input  logic             req,
   input  logic             en,
   input  logic             gnt,
   input  logic [WIDTH-1:0] data,
   output logic             ereq,
   output logic [WIDTH-1:0] data_m
);

   assign ereq   = req & en;
   assign data_m = gnt ? data : '0;

endmodule

module fifo_wr_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int BURST = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*WIDTH-1:0]    req_data,
   input  logic [NREQ-1:0]          req_en,
   output logic [NREQ-1:0]          gnt,
   input  logic                     fifo_full,
   output logic                     fifo_write,
   output logic [WIDTH-1:0]         fifo_data,
   output logic [$clog2(NREQ)-1:0]  owner,
   output logic [$clog2(BURST):0]   burst_cnt
);

   localparam int OW = $clog2(NREQ);
   localparam int BW = $clog2(BURST) + 1;

   // Result of the grant selection.
   typedef struct packed {
      logic          vld;
      logic [OW-1:0] idx;
   } sel_t;

   logic [NREQ-1:0]            ereq;
   logic [NREQ-1:0][WIDTH-1:0] data_m;

   sel_t          rr_sel;    // round-robin search winner
   sel_t          gnt_sel;   // final selection after quota and stall
   logic          cont;      // owner keeps the port under its burst quota
   logic [OW:0]   srch_idx;

   // ---------------------------------------------------------------------------
   // Lanes
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      fifo_wr_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
         .req    (req[i]),
         .en     (req_en[i]),
         .gnt    (gnt[i]),
         .data   (req_data[i*WIDTH +: WIDTH]),
         .ereq   (ereq[i]),
         .data_m (data_m[i])
      );
   end

   // ---------------------------------------------------------------------------
   // Round-robin search: candidates owner+1 .. owner+NREQ (mod NREQ), so the
   // owner itself is the last candidate. Walking from the far end lets the
   // nearest hit overwrite earlier ones. owner+k never exceeds 2*NREQ-1, so a
   // single conditional subtract implements the wrap.
   // ---------------------------------------------------------------------------
   always_comb begin
      rr_sel   = '0;
      srch_idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         srch_idx = {1'b0, owner} + (OW+1)'(k);
         if (srch_idx >= (OW+1)'(NREQ))
            srch_idx = srch_idx - (OW+1)'(NREQ);
         if (ereq[srch_idx[OW-1:0]]) begin
            rr_sel.vld = 1'b1;
            rr_sel.idx = srch_idx[OW-1:0];
         end
      end
   end

   // Quota continuation needs a live burst (cnt>=1) with room left. With
   // BURST=1 this is never true, which gives plain round-robin.
   assign cont = ereq[owner] && (burst_cnt != '0) && (burst_cnt < BW'(BURST));

   always_comb begin
      gnt_sel = '0;
      if (!rst && !fifo_full && (ereq != '0)) begin
         gnt_sel.vld = 1'b1;
         gnt_sel.idx = cont ? owner : rr_sel.idx;
      end
   end

   always_comb begin
      gnt = '0;
      for (int i = 0; i < NREQ; i++)
         gnt[i] = gnt_sel.vld && (gnt_sel.idx == OW'(i));
   end

   assign fifo_write = |gnt;

   // AND-OR mux: at most one lane contributes non-zero data.
   always_comb begin
      fifo_data = '0;
      for (int i = 0; i < NREQ; i++)
         fifo_data = fifo_data | data_m[i];
   end

   // ---------------------------------------------------------------------------
   // Owner / burst state. A stall holds everything; an idle cycle clears the
   // burst but keeps owner so the rotation resumes where it left off.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         owner     <= OW'(NREQ-1);
         burst_cnt <= '0;
      end else if (!fifo_full) begin
         if (ereq == '0) begin
            burst_cnt <= '0;
         end else if (cont) begin
            burst_cnt <= burst_cnt + 1'b1;
         end else begin
            // Covers both a new owner and the lone owner restarting its quota.
            owner     <= rr_sel.idx;
            burst_cnt <= BW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int BURST = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NREQ-1:0]         req, req_en, gnt;
   logic [NREQ*WIDTH-1:0]   req_data;
   logic                    fifo_full, fifo_write;
   logic [WIDTH-1:0]        fifo_data;
   logic [1:0]              owner;
   logic [1:0]              burst_cnt;

   fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_data   (req_data),
      .req_en     (req_en),
      .gnt        (gnt),
      .fifo_full  (fifo_full),
      .fifo_write (fifo_write),
      .fifo_data  (fifo_data),
      .owner      (owner),
      .burst_cnt  (burst_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state: who owns the port and how many words in a row it took.
   int m_owner;
   int m_run;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Which requester should win this cycle, or -1.
   function automatic int model_pick();
      logic [NREQ-1:0] act;
      act = req & req_en;
      if (rst || fifo_full || act == '0) return -1;
      if (act[m_owner] && m_run >= 1 && m_run < BURST) return m_owner;
      for (int k = 1; k <= NREQ; k++)
         if (act[(m_owner + k) % NREQ]) return (m_owner + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [WIDTH-1:0] word_of(input int i);
      return req_data[i*WIDTH +: WIDTH];
   endfunction

   // One clock: compare the combinational and registered outputs with the
   // model mid-cycle, take the edge, advance the model.
   task automatic cycle(output logic [NREQ-1:0] g, output logic w);
      int          pick;
      logic [31:0] exp_g, exp_d;
      pick  = model_pick();
      exp_g = (pick < 0) ? 32'd0 : (32'd1 << pick);
      exp_d = (pick < 0) ? 32'd0 : 32'(word_of(pick));
      #4;
      chk("gnt",        gnt,        exp_g);
      chk("fifo_write", fifo_write, (pick >= 0));
      chk("fifo_data",  fifo_data,  exp_d);
      chk("owner",      owner,      m_owner);
      chk("burst_cnt",  burst_cnt,  m_run);
      g = gnt;
      w = fifo_write;
      @(posedge clk);
      if (rst) begin
         m_owner = NREQ - 1;
         m_run   = 0;
      end else if (!fifo_full) begin
         if (pick < 0)                                         m_run = 0;
         else if (pick == m_owner && m_run >= 1 && m_run < BURST) m_run = m_run + 1;
         else begin
            m_owner = pick;
            m_run   = 1;
         end
      end
      #1;
   endtask

   logic [NREQ-1:0] g;
   logic            w;
   logic [NREQ-1:0] pend;
   int              t1_seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
   int              t2_cnt[5] = '{1, 2, 1, 2, 1};

   initial begin
      rst       = 1'b1;
      req       = '0;
      req_en    = '1;
      fifo_full = 1'b0;
      for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'(8'h10 + i);
      @(posedge clk); #1;
      m_owner = NREQ - 1;
      m_run   = 0;

      // Reset holds grant off even with everyone requesting.
      req = 4'b1111;
      cycle(g, w);
      chk("rst_gnt", g, 0);
      chk("rst_write", w, 0);
      chk("rst_owner", owner, 3);
      chk("rst_cnt", burst_cnt, 0);

      // Full rotation with burst quota of 2.
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         cycle(g, w);
         chk("rot_gnt", g, 32'd1 << t1_seq[i]);
      end

      // Lone requester restarts its quota each turn.
      req = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         cycle(g, w);
         chk("solo_gnt", g, 4'b0100);
         chk("solo_cnt", burst_cnt, t2_cnt[i]);
         chk("solo_owner", owner, 2);
      end

      // Stall mid-burst: get to owner=0,cnt=1, then two grants, then full.
      rst = 1'b1; req = '0; cycle(g, w);
      rst = 1'b0; req = 4'b0001; cycle(g, w);
      req = 4'b1111;
      cycle(g, w); chk("stall_pre0", g, 4'b0001);
      cycle(g, w); chk("stall_pre1", g, 4'b0010);
      fifo_full = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cycle(g, w);
         chk("stall_gnt", g, 0);
         chk("stall_write", w, 0);
         chk("stall_owner", owner, 1);
         chk("stall_cnt", burst_cnt, 1);
      end
      fifo_full = 1'b0;
      cycle(g, w); chk("stall_post0", g, 4'b0010);
      cycle(g, w); chk("stall_post1", g, 4'b0100);

      // Masked requester is never granted.
      req = 4'b0011; req_en = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         cycle(g, w);
         chk("mask_gnt", g, 4'b0010);
      end
      req_en = '1;

      // Owner drops after one grant: quota forfeited.
      rst = 1'b1; req = '0; cycle(g, w);
      rst = 1'b0; req = 4'b1111; cycle(g, w); chk("drop_first", g, 4'b0001);
      req = 4'b1110;
      cycle(g, w);
      chk("drop_gnt", g, 4'b0010);
      chk("drop_cnt", burst_cnt, 1);

      // Reset mid-burst.
      rst = 1'b1; req = '0; cycle(g, w);
      rst = 1'b0; req = 4'b0100; cycle(g, w);
      chk("mrst_owner_pre", owner, 2);
      chk("mrst_cnt_pre", burst_cnt, 1);
      req = 4'b1111; rst = 1'b1;
      cycle(g, w);
      chk("mrst_gnt", g, 0);
      chk("mrst_write", w, 0);
      chk("mrst_owner", owner, 3);
      chk("mrst_cnt", burst_cnt, 0);
      rst = 1'b0;
      cycle(g, w);
      chk("mrst_after", g, 4'b0001);

      // Randomized producers obeying the hold-until-grant contract, with
      // random masking, backpressure and occasional reset.
      pend = '0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++)
            if (!pend[i] && $urandom_range(0, 2) != 0) begin
               pend[i] = 1'b1;
               req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
         req       = pend;
         req_en    = ($urandom_range(0, 9) == 0) ? NREQ'($urandom) : '1;
         fifo_full = ($urandom_range(0, 3) == 0);
         rst       = ($urandom_range(0, 49) == 0);
         cycle(g, w);
         pend = pend & ~g;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port among NREQ producers.
- Each cycle it picks at most one requester and drives the FIFO's write strobe and data in the same cycle.
- It returns a per-requester grant, which tells the producer its word was accepted.
- A burst quota lets a requester keep ownership for up to BURST consecutive words, which preserves short packets without starving the other requesters.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, data word width; matches the FIFO WIDTH.
- BURST, 2, maximum consecutive grants to one requester while others are waiting (1..16).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  req[i]=1: requester i presents a valid word.
- req_data  in  NREQ*WIDTH  word of requester i on bits [i*WIDTH +: WIDTH].
- req_en  in  NREQ  per-requester enable mask; req[i] is ignored when req_en[i]=0.
- gnt  out  NREQ  one-hot or zero; gnt[i]=1 means requester i's word is written to the FIFO this cycle.
- fifo_full  in  1  full flag from the FIFO.
- fifo_write  out  1  FIFO write strobe.
- fifo_data  out  WIDTH  FIFO write data.
- owner  out  $clog2(NREQ)  index of the last granted requester (registered).
- burst_cnt  out  $clog2(BURST)+1  consecutive grants issued to owner (registered).

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - owner = NREQ-1, so requester 0 has first priority.
  - burst_cnt = 0.
  - gnt = 0 and fifo_write = 0 while rst=1, regardless of req.
- Effective request: ereq = req & req_en.
- Combinational grant: no registered latency from request to write. The word is in the FIFO at the clock edge where gnt[i]=1.
  - fifo_write = |gnt.
  - fifo_data = slice of the granted requester; 0 when there is no grant.
- Stall: if fifo_full=1, then gnt = 0 and fifo_write = 0. owner and burst_cnt hold.
- Grant selection when fifo_full=0 and ereq != 0:
  - Continue case: if ereq[owner]=1 and burst_cnt is between 1 and BURST-1, grant owner again. burst_cnt increments.
  - Otherwise, search from owner+1 upward, wrapping modulo NREQ, and grant the first set bit of ereq. The search includes owner itself as the last candidate.
  - If the winner equals the previous owner (no other requester active), burst_cnt restarts at 1.
  - If the winner is a different requester, owner takes the new index and burst_cnt = 1.
- Idle: if ereq = 0 with fifo_full=0, no grant and burst_cnt = 0. owner holds, which preserves round-robin fairness.
- Owner drop: if the owner drops req mid-burst, the quota is forfeited and the normal round-robin search runs that cycle.
- Masking: clearing req_en[i] mid-burst behaves exactly like req[i] dropping.
- BURST=1: pure round-robin, with at most one word per requester per turn.
- Producer contract: hold req and data stable until gnt is seen. On gnt, the producer either advances to its next word or deasserts req. The arbiter never grants a word twice.
- FIFO contract: fifo_full must be asserted in every cycle in which the FIFO cannot accept a write. The arbiter issues no speculative writes.
- Reset mid-burst: owner and burst_cnt are forced to their reset values. Words already granted remain in the FIFO; flushing the FIFO is the system's job.
- No combinational path from gnt back into req is permitted by producers (no loop).

Test Plan:
- Reset, then NREQ=4, BURST=2, req=1111 held with full=0 and data[i]=0x10+i. Required: gnt sequence 0,0,1,1,2,2,3,3,0. fifo_data sequence 10,10,11,11,12,12,13,13,10.
- Only req[2] held for 5 cycles. Required: gnt[2]=1 every cycle. burst_cnt sequence 1,2,1,2,1 and owner=2 throughout.
- req=1111 with fifo_full=1 asserted on the 3rd cycle for 2 cycles. Required: gnt=0 and fifo_write=0 for 2 cycles, owner=1 and burst_cnt=1 held. The next grant goes to 1, then 2.
- req=0011 with req_en=0010. Required: only gnt[1] ever asserts; requester 0 is never granted.
- Owner 0 drops req after 1 grant while req=1110 remains. Required: the next cycle grants 1 with burst_cnt=1.
- rst asserted mid-burst with owner=2 and burst_cnt=1, req=1111. Required: during rst, gnt=0 and fifo_write=0. The first cycle after rst grants requester 0.
